mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the CPU's instruction-fetch (IF) requester and its data-memory requester (driven by the control unit's DM_en/DM_write).
- Serializes accesses, sequences the fixed-latency memory handshake, returns read data, and drives a stall to the pipeline while any access is outstanding.
- Sits between the CPU core and the memory macro.

Parameters:
ADDR_W, 32, byte address width.
DATA_W, 32, data width; fixed at 32 because the write strobe is 4 bits.
MEM_LAT, 2, read latency in cycles from the mem_cs cycle to valid mem_rdata; legal range 1..7.
MAX_DM_STREAK, 4, number of consecutive DM grants allowed while IF waits; legal range 1..15.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, synchronous, active-low.
if_req  in  1  fetch request; held high with stable if_addr until if_done.
if_addr  in  ADDR_W  fetch byte address.
if_done  out  1  one-cycle completion pulse.
if_rdata  out  DATA_W  fetched word; valid while if_done=1.
dm_en  in  1  data request; held high with stable addr/data/write/wstrb until dm_done.
dm_write  in  1  1 = store, 0 = load.
dm_addr  in  ADDR_W  data byte address.
dm_wdata  in  DATA_W  store data.
dm_wstrb  in  4  store byte enables.
dm_done  out  1  one-cycle completion pulse.
dm_rdata  out  DATA_W  load data; valid while dm_done=1.
cpu_stall  out  1  pipeline stall.
mem_cs  out  1  memory chip select; one cycle per access.
mem_we  out  1  memory write enable.
mem_addr  out  ADDR_W  memory address.
mem_wdata  out  DATA_W  memory write data.
mem_wstrb  out  4  memory byte enables.
mem_rdata  in  DATA_W  memory read data.

Behaviour:
Reset:
- Clocked on clk; rst=0 at a rising edge resets the block.
- On reset: state=IDLE; mem_cs=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0; if_done=0, dm_done=0, if_rdata=0, dm_rdata=0; streak counter=0; latency counter=0.

FSM states:
- IDLE: arbitrate.
- ISSUE: mem_cs=1 for exactly one cycle.
- WAIT: reads only; MEM_LAT cycles.
- RESP: done pulse for the granted owner.
- Transitions:
  - IDLE to ISSUE when any request is present.
  - ISSUE to WAIT for a read; ISSUE to RESP for a write.
  - WAIT to RESP when the latency counter expires.
  - RESP to IDLE unconditionally.

Arbitration (IDLE only):
- If both requests are high, DM wins unless streak==MAX_DM_STREAK; in that case IF wins.
- The grant owner, address, data, write flag and strobe are registered at the arbitration edge.
- mem_* outputs are registered and valid during the ISSUE cycle only; outside ISSUE, mem_cs=0 and mem_we=0.
- IF accesses always have mem_we=0 and mem_wstrb=4'b0000. DM reads drive mem_wstrb=0.

Streak counter:
- Increments on a DM grant while if_req=1.
- Clears on an IF grant, and on any grant while if_req=0.
- Saturates at MAX_DM_STREAK.

Timing, with E0 the arbitration edge:
- Read: ISSUE is cycle 1. mem_rdata is sampled at the end of cycle 1+MEM_LAT. Done and rdata appear in cycle MEM_LAT+2.
- Write: done appears in cycle 2.
- The next arbitration occurs at the end of the RESP cycle. A requester sampled in RESP is ignored.
- A requester must drop its request, or present a new one, in the cycle after its done pulse.

Data outputs:
- if_rdata and dm_rdata hold their last value; only the owner's register is updated.
- dm_rdata is unchanged on writes.

cpu_stall:
- Combinational: (if_req & ~if_done) | (dm_en & ~dm_done).
- Forced to 0 while rst=0.

Reset mid-access:
- The FSM returns to IDLE.
- The in-flight read is discarded; no done pulse is emitted.
- Requesters must re-issue.

Requests dropped before done:
- Protocol violation; the arbiter still completes the access and pulses done.

Decomposition:
- Package mem_arb_pkg:
  - typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t
  - typedef enum logic {OWN_IF, OWN_DM} owner_t
  - localparam WSTRB_W = 4
- Sub-module arb_streak_ctr: the saturating streak counter with clear and increment inputs.
- The latency counter stays inline.

Test Plan:
- Reset then idle: rst=0 for 2 cycles with if_req=1 -> mem_cs=0, if_done=0, cpu_stall=0. Release rst -> ISSUE with mem_addr=if_addr.
- IF read, MEM_LAT=2: if_addr=0x100, mem_rdata=0xDEADBEEF in the cycle 2 after ISSUE -> if_done=1 and if_rdata=0xDEADBEEF exactly 4 cycles after the arbitration edge.
- DM store: dm_en=1, dm_write=1, dm_addr=0x2004, dm_wdata=0x12345678, dm_wstrb=4'b0011 -> one ISSUE cycle with mem_we=1, mem_wstrb=0011; dm_done in cycle 2; dm_rdata unchanged.
- Simultaneous: if_req and dm_en both high, dm_write=0 -> DM is granted first. IF is granted in the IDLE following DM's RESP. cpu_stall stays 1 until if_done.
- Starvation, MAX_DM_STREAK=4: dm_en held continuously with a new load each time, if_req=1 -> exactly 4 DM grants, then 1 IF grant, then DM again.
- Reset mid-read: rst=0 during WAIT -> no dm_done, state IDLE. The re-issued request completes normally with correct data.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types for the unified-memory port arbiter.
//   arb_state_t : arbiter sequencing states (IDLE, ISSUE, WAIT, RESP)
//   owner_t     : which requester currently owns the memory port
//   WSTRB_W     : width of the byte write strobe (one bit per byte of 32 bits)
// No ports; imported by the interface, the top and its sub-module.
// ---------------------------------------------------------------------------
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_t;

   localparam int WSTRB_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles every bus signal around the arbiter: the instruction-fetch request
// channel, the data-memory request channel, the pipeline stall, and the
// single memory-macro port.
//   slave  modport : the arbiter's view (takes requests, drives the memory)
//   master modport : the surrounding system's view (CPU requesters + memory)
// Parameters: ADDR_W byte address width, DATA_W data width.
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   import mem_arb_pkg::*;

   // Instruction-fetch channel
   logic               if_req;
   logic [ADDR_W-1:0]  if_addr;
   logic               if_done;
   logic [DATA_W-1:0]  if_rdata;

   // Data-memory channel
   logic               dm_en;
   logic               dm_write;
   logic [ADDR_W-1:0]  dm_addr;
   logic [DATA_W-1:0]  dm_wdata;
   logic [WSTRB_W-1:0] dm_wstrb;
   logic               dm_done;
   logic [DATA_W-1:0]  dm_rdata;

   // Pipeline stall
   logic               cpu_stall;

   // Memory macro port
   logic               mem_cs;
   logic               mem_we;
   logic [ADDR_W-1:0]  mem_addr;
   logic [DATA_W-1:0]  mem_wdata;
   logic [WSTRB_W-1:0] mem_wstrb;
   logic [DATA_W-1:0]  mem_rdata;

   modport slave (
      input  if_req, if_addr,
      input  dm_en, dm_write, dm_addr, dm_wdata, dm_wstrb,
      input  mem_rdata,
      output if_done, if_rdata,
      output dm_done, dm_rdata,
      output cpu_stall,
      output mem_cs, mem_we, mem_addr, mem_wdata, mem_wstrb
   );

   modport master (
      output if_req, if_addr,
      output dm_en, dm_write, dm_addr, dm_wdata, dm_wstrb,
      output mem_rdata,
      input  if_done, if_rdata,
      input  dm_done, dm_rdata,
      input  cpu_stall,
      input  mem_cs, mem_we, mem_addr, mem_wdata, mem_wstrb
   );

endinterface

// File: rtl/mem_port_arbiter_streak_ctr.sv
// ---------------------------------------------------------------------------
// arb_streak_ctr
// Counts consecutive data-memory grants made while a fetch is waiting, so the
// arbiter can hand the port to the fetch once the streak reaches its limit.
// Ports:
//   clk, rst  : clock, synchronous active-low reset
//   i_clr     : clear the streak (takes priority over i_inc)
//   i_inc     : add one, saturating at MAX_DM_STREAK
//   o_streak  : current streak value
// ---------------------------------------------------------------------------
module arb_streak_ctr #(
   parameter int MAX_DM_STREAK = 4,
   parameter int CNT_W         = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_streak
);

   localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_DM_STREAK);

   logic [CNT_W-1:0] r_streak;

   // Saturating counter: holds at the limit so the arbiter keeps seeing the
   // "fetch must win" condition until a clearing grant happens.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_streak <= '0;
      end else if (i_clr) begin
         r_streak <= '0;
      end else if (i_inc && (r_streak != STREAK_MAX)) begin
         r_streak <= r_streak + 1'b1;
      end
   end

   assign o_streak = r_streak;

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port unified memory between the instruction-fetch and
// data-memory requesters. One access at a time: arbitrate in IDLE, drive the
// memory for one ISSUE cycle, wait MEM_LAT cycles on reads, then pulse the
// owner's done in RESP. The pipeline is stalled while any request is pending.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-low reset
//   bus  : mem_port_arbiter_if.slave (fetch channel, data channel,
//          cpu_stall, memory macro port)
// Parameters: ADDR_W, DATA_W (32), MEM_LAT (1..7), MAX_DM_STREAK (1..15).
// ---------------------------------------------------------------------------
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W        = 32,
   parameter int DATA_W        = 32,
   parameter int MEM_LAT       = 2,
   parameter int MAX_DM_STREAK = 4
) (
   input  logic                clk,
   input  logic                rst,
   mem_port_arbiter_if.slave   bus
);

   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_ISSUE = ISSUE;
   localparam logic [1:0] S_WAIT  = WAIT;
   localparam logic [1:0] S_RESP  = RESP;

   localparam int               STREAK_W   = 4;
   localparam int               LAT_W      = 3;
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);
   localparam logic [LAT_W-1:0] LAT_LOAD   = LAT_W'(MEM_LAT - 1);

   logic [1:0]          r_state;
   owner_t              r_owner;
   logic [LAT_W-1:0]    r_latCnt;
   logic                r_memCs;
   logic                r_memWe;
   logic [ADDR_W-1:0]   r_memAddr;
   logic [DATA_W-1:0]   r_memWdata;
   logic [WSTRB_W-1:0]  r_memWstrb;
   logic                r_ifDone;
   logic                r_dmDone;
   logic [DATA_W-1:0]   r_ifRdata;
   logic [DATA_W-1:0]   r_dmRdata;

   logic                w_anyReq;
   logic                w_grantDm;
   logic                w_arbitrate;
   logic                w_streakInc;
   logic                w_streakClr;
   logic [STREAK_W-1:0] w_streak;

   // Data wins a tie unless it has already taken the port MAX_DM_STREAK times
   // in a row while the fetch was waiting; then the fetch goes next.
   assign w_anyReq    = bus.if_req | bus.dm_en;
   assign w_grantDm   = bus.dm_en & ~(bus.if_req & (w_streak == STREAK_MAX));
   assign w_arbitrate = (r_state == S_IDLE) & w_anyReq;
   assign w_streakInc = w_arbitrate & w_grantDm & bus.if_req;
   assign w_streakClr = w_arbitrate & ~w_streakInc;

   arb_streak_ctr #(
      .MAX_DM_STREAK (MAX_DM_STREAK),
      .CNT_W         (STREAK_W)
   ) u_streak (
      .clk      (clk),
      .rst      (rst),
      .i_clr    (w_streakClr),
      .i_inc    (w_streakInc),
      .o_streak (w_streak)
   );

   // Main sequencer. The memory command is captured at the arbitration edge so
   // it is stable for the whole ISSUE cycle; chip select and write enable are
   // defaulted low so they can only be high during ISSUE. The done pulses are
   // set on entry to RESP and defaulted low, giving exactly one cycle each.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_owner    <= OWN_IF;
         r_latCnt   <= '0;
         r_memCs    <= 1'b0;
         r_memWe    <= 1'b0;
         r_memAddr  <= '0;
         r_memWdata <= '0;
         r_memWstrb <= '0;
         r_ifDone   <= 1'b0;
         r_dmDone   <= 1'b0;
         r_ifRdata  <= '0;
         r_dmRdata  <= '0;
      end else begin
         r_memCs  <= 1'b0;
         r_memWe  <= 1'b0;
         r_ifDone <= 1'b0;
         r_dmDone <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_anyReq) begin
                  r_state <= S_ISSUE;
                  r_memCs <= 1'b1;
                  if (w_grantDm) begin
                     r_owner    <= OWN_DM;
                     r_memWe    <= bus.dm_write;
                     r_memAddr  <= bus.dm_addr;
                     r_memWdata <= bus.dm_write ? bus.dm_wdata : '0;
                     r_memWstrb <= bus.dm_write ? bus.dm_wstrb : '0;
                  end else begin
                     r_owner    <= OWN_IF;
                     r_memWe    <= 1'b0;
                     r_memAddr  <= bus.if_addr;
                     r_memWdata <= '0;
                     r_memWstrb <= '0;
                  end
               end
            end
            S_ISSUE: begin
               // Writes complete immediately; reads wait out the memory latency.
               if (r_memWe) begin
                  r_state <= S_RESP;
                  if (r_owner == OWN_DM) begin
                     r_dmDone <= 1'b1;
                  end else begin
                     r_ifDone <= 1'b1;
                  end
               end else begin
                  r_state  <= S_WAIT;
                  r_latCnt <= LAT_LOAD;
               end
            end
            S_WAIT: begin
               // Read data is valid on the last WAIT cycle; only the owner's
               // data register is updated so the other keeps its last value.
               if (r_latCnt == '0) begin
                  r_state <= S_RESP;
                  if (r_owner == OWN_DM) begin
                     r_dmRdata <= bus.mem_rdata;
                     r_dmDone  <= 1'b1;
                  end else begin
                     r_ifRdata <= bus.mem_rdata;
                     r_ifDone  <= 1'b1;
                  end
               end else begin
                  r_latCnt <= r_latCnt - 1'b1;
               end
            end
            S_RESP: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.mem_cs    = r_memCs;
   assign bus.mem_we    = r_memWe;
   assign bus.mem_addr  = r_memAddr;
   assign bus.mem_wdata = r_memWdata;
   assign bus.mem_wstrb = r_memWstrb;
   assign bus.if_done   = r_ifDone;
   assign bus.if_rdata  = r_ifRdata;
   assign bus.dm_done   = r_dmDone;
   assign bus.dm_rdata  = r_dmRdata;

   // Stall is combinational so the pipeline freezes in the same cycle a request
   // appears, and releases in the cycle its done pulse arrives.
   assign bus.cpu_stall = rst & ((bus.if_req & ~r_ifDone) | (bus.dm_en & ~r_dmDone));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter. Expected memory commands and done
// responses are queued when stimulus is planned; a monitor pops and compares
// them whenever the arbiter drives mem_cs or a done pulse. A small memory
// model returns read data exactly MEM_LAT cycles after the ISSUE cycle.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int MEM_LAT       = 2;
   localparam int MAX_DM_STREAK = 4;
   localparam logic [31:0] GARBAGE = 32'hBAD0BAD0;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(
      .ADDR_W        (32),
      .DATA_W        (32),
      .MEM_LAT       (MEM_LAT),
      .MAX_DM_STREAK (MAX_DM_STREAK)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      bit          isDone;
      owner_t      own;
      logic [31:0] addr;
      bit          we;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } ev_t;

   ev_t         expQ[$];
   int          total = 0;
   int          bad   = 0;
   int          cycle = 0;
   int          issueCycle = 0;
   logic [31:0] memImage [logic [31:0]];
   int          latCnt = 0;
   logic [31:0] pendData = '0;

   // Single comparison point: every check steps total, every miss steps bad.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h want 0x%08h", name, actual, expected);
      end
   endtask

   // Queue the memory command (and optionally the done response) expected
   // from one access; rdata is the value the owner's data output must show.
   task automatic expectAccess(input owner_t own, input bit we,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wstrb, input logic [31:0] rdata,
                               input bit withDone);
      ev_t e;
      e.isDone = 1'b0;
      e.own    = own;
      e.addr   = addr;
      e.we     = we;
      e.wstrb  = wstrb;
      e.wdata  = wdata;
      e.rdata  = rdata;
      expQ.push_back(e);
      if (withDone) begin
         e.isDone = 1'b1;
         expQ.push_back(e);
      end
   endtask

   // Present one request (called just after a rising edge), hold it until the
   // done pulse, then drop it in the following cycle if asked to.
   task automatic applyStimulus(input owner_t own, input bit we,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] wstrb, input bit dropAfter);
      int n;
      bit got;
      if (own == OWN_IF) begin
         bus.if_req  = 1'b1;
         bus.if_addr = addr;
      end else begin
         bus.dm_en    = 1'b1;
         bus.dm_write = we;
         bus.dm_addr  = addr;
         bus.dm_wdata = wdata;
         bus.dm_wstrb = wstrb;
      end
      n   = 0;
      got = 1'b0;
      while (!got && n < 60) begin
         @(negedge clk);
         n++;
         got = (own == OWN_IF) ? (bus.if_done === 1'b1) : (bus.dm_done === 1'b1);
      end
      if (!got) begin
         total++;
         bad++;
         $display("[TB] FAIL doneTimeout: got no done want done for addr 0x%08h", addr);
      end
      @(posedge clk);
      #1;
      if (dropAfter) begin
         if (own == OWN_IF) bus.if_req = 1'b0;
         else               bus.dm_en  = 1'b0;
      end
   endtask

   always @(posedge clk) cycle++;

   // Memory model: read data appears only in the cycle MEM_LAT after ISSUE.
   always @(negedge clk) begin
      if (latCnt > 0) begin
         latCnt--;
         bus.mem_rdata = (latCnt == 0) ? pendData : GARBAGE;
      end else begin
         bus.mem_rdata = GARBAGE;
      end
      if (bus.mem_cs === 1'b1 && bus.mem_we === 1'b0) begin
         latCnt   = MEM_LAT;
         pendData = memImage.exists(bus.mem_addr) ? memImage[bus.mem_addr] : GARBAGE;
      end
   end

   // Monitor: compare every memory command and done pulse with the queue.
   always @(negedge clk) begin
      ev_t e;
      if (bus.mem_cs === 1'b1) begin
         if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpectedIssue: got mem_cs addr 0x%08h want none", bus.mem_addr);
         end else begin
            e = expQ.pop_front();
            checkOutput("eventIsIssue", 32'(0), 32'(e.isDone));
            checkOutput("memAddr", bus.mem_addr, e.addr);
            checkOutput("memWe", 32'(bus.mem_we), 32'(e.we));
            checkOutput("memWstrb", 32'(bus.mem_wstrb), 32'(e.wstrb));
            if (e.we) checkOutput("memWdata", bus.mem_wdata, e.wdata);
            issueCycle = cycle;
         end
      end
      if (bus.if_done === 1'b1 || bus.dm_done === 1'b1) begin
         if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpectedDone: got if_done=%0b dm_done=%0b want none",
                     bus.if_done, bus.dm_done);
         end else begin
            e = expQ.pop_front();
            checkOutput("eventIsDone", 32'(1), 32'(e.isDone));
            checkOutput("singleDone", 32'(bus.if_done & bus.dm_done), 32'(0));
            checkOutput("doneOwner", 32'(bus.dm_done), 32'(e.own));
            if (e.own == OWN_IF) checkOutput("ifRdata", bus.if_rdata, e.rdata);
            else                 checkOutput("dmRdata", bus.dm_rdata, e.rdata);
            checkOutput("doneLatency", 32'(cycle - issueCycle),
                        e.we ? 32'(1) : 32'(MEM_LAT + 1));
         end
      end
   end

   initial begin
      #50000;
      bad++;
      $display("[TB] FAIL watchdog: got no completion want finish before 50000");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      bus.if_req   = 1'b1;
      bus.if_addr  = 32'h0000_0100;
      bus.dm_en    = 1'b0;
      bus.dm_write = 1'b0;
      bus.dm_addr  = '0;
      bus.dm_wdata = '0;
      bus.dm_wstrb = '0;
      memImage[32'h0000_0100] = 32'hDEAD_BEEF;
      memImage[32'h0000_2000] = 32'hCAFE_F00D;
      memImage[32'h0000_3000] = 32'hA5A5_1234;
      memImage[32'h0000_0104] = 32'h600D_F00D;
      memImage[32'h0000_4000] = 32'h1111_0000;
      memImage[32'h0000_4004] = 32'h2222_0004;
      memImage[32'h0000_4008] = 32'h3333_0008;
      memImage[32'h0000_400C] = 32'h4444_000C;
      memImage[32'h0000_4010] = 32'h5555_0010;
      memImage[32'h0000_0108] = 32'h0108_0108;
      memImage[32'h0000_5000] = 32'h5A5A_5A5A;

      // Reset held for two edges with a fetch pending: everything quiet.
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rstMemCs", 32'(bus.mem_cs), 32'(0));
      checkOutput("rstMemWe", 32'(bus.mem_we), 32'(0));
      checkOutput("rstMemAddr", bus.mem_addr, 32'h0);
      checkOutput("rstIfDone", 32'(bus.if_done), 32'(0));
      checkOutput("rstDmDone", 32'(bus.dm_done), 32'(0));
      checkOutput("rstIfRdata", bus.if_rdata, 32'h0);
      checkOutput("rstDmRdata", bus.dm_rdata, 32'h0);
      checkOutput("rstStall", 32'(bus.cpu_stall), 32'(0));

      // Release reset: the held fetch is issued at the next edge.
      expectAccess(OWN_IF, 1'b0, 32'h0000_0100, 32'h0, 4'b0000, 32'hDEAD_BEEF, 1'b1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      applyStimulus(OWN_IF, 1'b0, 32'h0000_0100, 32'h0, 4'b0000, 1'b1);
      @(negedge clk);
      checkOutput("idleStall", 32'(bus.cpu_stall), 32'(0));
      @(posedge clk);
      #1;

      // Data load, then a store that must leave dm_rdata untouched.
      expectAccess(OWN_DM, 1'b0, 32'h0000_2000, 32'h0, 4'b0000, 32'hCAFE_F00D, 1'b1);
      applyStimulus(OWN_DM, 1'b0, 32'h0000_2000, 32'h0, 4'b0000, 1'b1);
      expectAccess(OWN_DM, 1'b1, 32'h0000_2004, 32'h1234_5678, 4'b0011, 32'hCAFE_F00D, 1'b1);
      applyStimulus(OWN_DM, 1'b1, 32'h0000_2004, 32'h1234_5678, 4'b0011, 1'b1);

      // Simultaneous requests: data first, then fetch; stall held until if_done.
      expectAccess(OWN_DM, 1'b0, 32'h0000_3000, 32'h0, 4'b0000, 32'hA5A5_1234, 1'b1);
      expectAccess(OWN_IF, 1'b0, 32'h0000_0104, 32'h0, 4'b0000, 32'h600D_F00D, 1'b1);
      fork
         applyStimulus(OWN_DM, 1'b0, 32'h0000_3000, 32'h0, 4'b0000, 1'b1);
         applyStimulus(OWN_IF, 1'b0, 32'h0000_0104, 32'h0, 4'b0000, 1'b1);
         begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 40 && !seen; k++) begin
               @(negedge clk);
               if (bus.if_done === 1'b1) begin
                  checkOutput("stallAtIfDone", 32'(bus.cpu_stall), 32'(0));
                  seen = 1'b1;
               end else begin
                  checkOutput("stallHeld", 32'(bus.cpu_stall), 32'(1));
               end
            end
         end
      join

      // Starvation: four back-to-back data loads, then the fetch, then data.
      expectAccess(OWN_DM, 1'b0, 32'h0000_4000, 32'h0, 4'b0000, 32'h1111_0000, 1'b1);
      expectAccess(OWN_DM, 1'b0, 32'h0000_4004, 32'h0, 4'b0000, 32'h2222_0004, 1'b1);
      expectAccess(OWN_DM, 1'b0, 32'h0000_4008, 32'h0, 4'b0000, 32'h3333_0008, 1'b1);
      expectAccess(OWN_DM, 1'b0, 32'h0000_400C, 32'h0, 4'b0000, 32'h4444_000C, 1'b1);
      expectAccess(OWN_IF, 1'b0, 32'h0000_0108, 32'h0, 4'b0000, 32'h0108_0108, 1'b1);
      expectAccess(OWN_DM, 1'b0, 32'h0000_4010, 32'h0, 4'b0000, 32'h5555_0010, 1'b1);
      fork
         begin
            for (int k = 0; k < 5; k++) begin
               applyStimulus(OWN_DM, 1'b0, 32'h0000_4000 + 32'(4 * k), 32'h0, 4'b0000,
                             (k == 4));
            end
         end
         applyStimulus(OWN_IF, 1'b0, 32'h0000_0108, 32'h0, 4'b0000, 1'b1);
      join

      // Reset during WAIT: the load is dropped without a done pulse.
      expectAccess(OWN_DM, 1'b0, 32'h0000_5000, 32'h0, 4'b0000, 32'h0, 1'b0);
      bus.dm_en    = 1'b1;
      bus.dm_write = 1'b0;
      bus.dm_addr  = 32'h0000_5000;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midRstStall", 32'(bus.cpu_stall), 32'(0));
      checkOutput("midRstDmDone", 32'(bus.dm_done), 32'(0));
      @(posedge clk);
      @(negedge clk);
      checkOutput("midRstMemCs", 32'(bus.mem_cs), 32'(0));
      checkOutput("midRstDmDone2", 32'(bus.dm_done), 32'(0));
      checkOutput("midRstDmRdata", bus.dm_rdata, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      expectAccess(OWN_DM, 1'b0, 32'h0000_5000, 32'h0, 4'b0000, 32'h5A5A_5A5A, 1'b1);
      applyStimulus(OWN_DM, 1'b0, 32'h0000_5000, 32'h0, 4'b0000, 1'b1);

      repeat (4) @(negedge clk);
      checkOutput("queueDrained", 32'(expQ.size()), 32'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
